// File: rtl/dual_mem_wb.sv
// rtl/dual_mem_wb.sv - dual-issue MEM stage with data memory, branch resolution and MEM/WB register
//
// Purpose:
//    Takes both EX/MEM slot bundles and performs their data-memory accesses.
//    Slot 1 is always the older instruction. When both slots touch memory in
//    the same bundle, the accesses are serialised over two cycles. The block
//    resolves branch mispredictions and registers the write-back bundle.
//
// Ports:
//    clk, rst                   rising-edge clock, asynchronous active-high reset
//    aluRes{1,2}_MEM            ALU result; its low ADDR_W bits are the word address
//    forwardBRes{1,2}_MEM       store data
//    MemReadEn/MemWriteEn/MemtoReg/RegWriteEn/jal{1,2}_MEM   slot controls
//    DestReg{1,2}_MEM           destination register
//    return_addr{1,2}_MEM       PC+1 of the slot
//    BranchAddress{1,2}_MEM     branch target
//    Branch/taken/predicted{1,2}_MEM   branch flag, actual outcome, fetch prediction
//    stall_mem                  upstream holds EX/MEM and earlier stages
//    correct_en, correction     misprediction redirect strobe and target PC
//    flush_IFID, flush_IDEX     pipeline flushes, equal to correct_en
//    writeData/aluRes/writeReg/regWrite/jal{1,2}_WB   registered write-back bundle
module dual_mem_wb #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] aluRes1_MEM,
   input  logic [DATA_W-1:0] aluRes2_MEM,
   input  logic [DATA_W-1:0] forwardBRes1_MEM,
   input  logic [DATA_W-1:0] forwardBRes2_MEM,
   input  logic              MemReadEn1_MEM,
   input  logic              MemReadEn2_MEM,
   input  logic              MemWriteEn1_MEM,
   input  logic              MemWriteEn2_MEM,
   input  logic              MemtoReg1_MEM,
   input  logic              MemtoReg2_MEM,
   input  logic              RegWriteEn1_MEM,
   input  logic              RegWriteEn2_MEM,
   input  logic              jal1_MEM,
   input  logic              jal2_MEM,
   input  logic [4:0]        DestReg1_MEM,
   input  logic [4:0]        DestReg2_MEM,
   input  logic [9:0]        return_addr1_MEM,
   input  logic [9:0]        return_addr2_MEM,
   input  logic [9:0]        BranchAddress1_MEM,
   input  logic [9:0]        BranchAddress2_MEM,
   input  logic              Branch1_MEM,
   input  logic              Branch2_MEM,
   input  logic              taken1_MEM,
   input  logic              taken2_MEM,
   input  logic              predicted1_MEM,
   input  logic              predicted2_MEM,
   output logic              stall_mem,
   output logic              correct_en,
   output logic [9:0]        correction,
   output logic              flush_IFID,
   output logic              flush_IDEX,
   output logic [DATA_W-1:0] writeData1_WB,
   output logic [DATA_W-1:0] writeData2_WB,
   output logic [DATA_W-1:0] aluRes1_WB,
   output logic [DATA_W-1:0] aluRes2_WB,
   output logic [4:0]        writeReg1_WB,
   output logic [4:0]        writeReg2_WB,
   output logic              regWrite1_WB,
   output logic              regWrite2_WB,
   output logic              jal1_WB,
   output logic              jal2_WB
);

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] mem_array [DEPTH];

   logic [ADDR_W-1:0] addr1, addr2;
   logic [DATA_W-1:0] rd_data1, rd_data2;
   logic              mem1, mem2, mis1, mis2, conflict;
   logic              retire, we1, we2;

   logic [DATA_W-1:0] load_buf_q, load_buf_d;
   logic [DATA_W-1:0] ld_data1;

   logic [DATA_W-1:0] writeData1_q, writeData1_d, writeData2_q, writeData2_d;
   logic [DATA_W-1:0] aluRes1_q, aluRes1_d, aluRes2_q, aluRes2_d;
   logic [4:0]        writeReg1_q, writeReg1_d, writeReg2_q, writeReg2_d;
   logic              regWrite1_q, regWrite1_d, regWrite2_q, regWrite2_d;
   logic              jal1_q, jal1_d, jal2_q, jal2_d;

   // Decode. Addresses wrap modulo DEPTH because only the low bits are used.
   assign addr1    = aluRes1_MEM[ADDR_W-1:0];
   assign addr2    = aluRes2_MEM[ADDR_W-1:0];
   assign mem1     = MemReadEn1_MEM | MemWriteEn1_MEM;
   assign mem2     = MemReadEn2_MEM | MemWriteEn2_MEM;
   assign mis1     = Branch1_MEM & (taken1_MEM != predicted1_MEM);
   assign mis2     = Branch2_MEM & (taken2_MEM != predicted2_MEM);
   // A mispredicted slot 1 squashes slot 2, so its access never needs a second cycle.
   assign conflict = mem1 & mem2 & ~mis1;

   // Asynchronous reads. In SECOND, slot 1's store has already landed, so a
   // same-address slot-2 load observes it without any bypass.
   assign rd_data1 = mem_array[addr1];
   assign rd_data2 = mem_array[addr2];

   // FSM next state, stall and write enables.
   always_comb begin
      state_d    = state_q;
      stall_mem  = 1'b0;
      retire     = 1'b0;
      we1        = 1'b0;
      we2        = 1'b0;
      load_buf_d = load_buf_q;
      case (state_q)
         IDLE: begin
            we1 = MemWriteEn1_MEM;
            if (conflict) begin
               stall_mem  = 1'b1;
               load_buf_d = rd_data1;
               state_d    = SECOND;
            end else begin
               retire = 1'b1;
               we2    = MemWriteEn2_MEM & ~mis1;
            end
         end
         SECOND: begin
            retire  = 1'b1;
            we2     = MemWriteEn2_MEM & ~mis1;
            state_d = IDLE;
         end
      endcase
   end

   // Redirect and write-back bundle.
   always_comb begin
      correct_en = retire & (mis1 | mis2);
      correction = 10'd0;
      if (retire && mis1) begin
         correction = taken1_MEM ? BranchAddress1_MEM : return_addr1_MEM;
      end else if (retire && mis2) begin
         correction = taken2_MEM ? BranchAddress2_MEM : return_addr2_MEM;
      end
      flush_IFID = correct_en;
      flush_IDEX = correct_en;

      // Slot 1 load data was parked in the buffer during the conflict cycle.
      ld_data1 = (state_q == SECOND) ? load_buf_q : rd_data1;

      writeData1_d = writeData1_q;
      writeData2_d = writeData2_q;
      aluRes1_d    = aluRes1_q;
      aluRes2_d    = aluRes2_q;
      writeReg1_d  = writeReg1_q;
      writeReg2_d  = writeReg2_q;
      regWrite1_d  = 1'b0;
      regWrite2_d  = 1'b0;
      jal1_d       = 1'b0;
      jal2_d       = 1'b0;

      if (retire) begin
         if (jal1_MEM) begin
            writeData1_d = {{(DATA_W-10){1'b0}}, return_addr1_MEM};
         end else if (MemtoReg1_MEM) begin
            writeData1_d = ld_data1;
         end else begin
            writeData1_d = aluRes1_MEM;
         end
         if (jal2_MEM) begin
            writeData2_d = {{(DATA_W-10){1'b0}}, return_addr2_MEM};
         end else if (MemtoReg2_MEM) begin
            writeData2_d = rd_data2;
         end else begin
            writeData2_d = aluRes2_MEM;
         end
         aluRes1_d   = aluRes1_MEM;
         aluRes2_d   = aluRes2_MEM;
         writeReg1_d = DestReg1_MEM;
         writeReg2_d = DestReg2_MEM;
         regWrite1_d = RegWriteEn1_MEM;
         regWrite2_d = RegWriteEn2_MEM & ~mis1;
         jal1_d      = jal1_MEM;
         jal2_d      = jal2_MEM;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         load_buf_q   <= '0;
         writeData1_q <= '0;
         writeData2_q <= '0;
         aluRes1_q    <= '0;
         aluRes2_q    <= '0;
         writeReg1_q  <= '0;
         writeReg2_q  <= '0;
         regWrite1_q  <= 1'b0;
         regWrite2_q  <= 1'b0;
         jal1_q       <= 1'b0;
         jal2_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_buf_q   <= load_buf_d;
         writeData1_q <= writeData1_d;
         writeData2_q <= writeData2_d;
         aluRes1_q    <= aluRes1_d;
         aluRes2_q    <= aluRes2_d;
         writeReg1_q  <= writeReg1_d;
         writeReg2_q  <= writeReg2_d;
         regWrite1_q  <= regWrite1_d;
         regWrite2_q  <= regWrite2_d;
         jal1_q       <= jal1_d;
         jal2_q       <= jal2_d;
      end
   end

   // Memory contents survive reset; a write pending at a reset edge is dropped.
   // we1 and we2 are never both set in one cycle, so the ports never collide.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (we1) begin
            mem_array[addr1] <= forwardBRes1_MEM;
         end
         if (we2) begin
            mem_array[addr2] <= forwardBRes2_MEM;
         end
      end
   end

   assign writeData1_WB = writeData1_q;
   assign writeData2_WB = writeData2_q;
   assign aluRes1_WB    = aluRes1_q;
   assign aluRes2_WB    = aluRes2_q;
   assign writeReg1_WB  = writeReg1_q;
   assign writeReg2_WB  = writeReg2_q;
   assign regWrite1_WB  = regWrite1_q;
   assign regWrite2_WB  = regWrite2_q;
   assign jal1_WB       = jal1_q;
   assign jal2_WB       = jal2_q;

endmodule

// File: tb/tb_dual_mem_wb.sv
// tb/tb_dual_mem_wb.sv - self-checking bench for dual_mem_wb
module tb_dual_mem_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] aluRes1_MEM, aluRes2_MEM, forwardBRes1_MEM, forwardBRes2_MEM;
   logic        MemReadEn1_MEM, MemReadEn2_MEM, MemWriteEn1_MEM, MemWriteEn2_MEM;
   logic        MemtoReg1_MEM, MemtoReg2_MEM, RegWriteEn1_MEM, RegWriteEn2_MEM;
   logic        jal1_MEM, jal2_MEM;
   logic [4:0]  DestReg1_MEM, DestReg2_MEM;
   logic [9:0]  return_addr1_MEM, return_addr2_MEM, BranchAddress1_MEM, BranchAddress2_MEM;
   logic        Branch1_MEM, Branch2_MEM, taken1_MEM, taken2_MEM, predicted1_MEM, predicted2_MEM;
   logic        stall_mem, correct_en, flush_IFID, flush_IDEX;
   logic [9:0]  correction;
   logic [31:0] writeData1_WB, writeData2_WB, aluRes1_WB, aluRes2_WB;
   logic [4:0]  writeReg1_WB, writeReg2_WB;
   logic        regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB;

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [1024];
   logic        obs_stall, obs_ce;
   logic [9:0]  obs_corr;

   typedef struct {
      logic [31:0] alu1, alu2, fb1, fb2;
      logic        rd1, rd2, wr1, wr2, m2r1, m2r2, rw1, rw2, jl1, jl2;
      logic [4:0]  d1, d2;
      logic [9:0]  ra1, ra2, ba1, ba2;
      logic        br1, br2, tk1, tk2, pr1, pr2;
   } bundle_t;

   always #5 clk = ~clk;

   dual_mem_wb dut (
      .clk(clk), .rst(rst),
      .aluRes1_MEM(aluRes1_MEM), .aluRes2_MEM(aluRes2_MEM),
      .forwardBRes1_MEM(forwardBRes1_MEM), .forwardBRes2_MEM(forwardBRes2_MEM),
      .MemReadEn1_MEM(MemReadEn1_MEM), .MemReadEn2_MEM(MemReadEn2_MEM),
      .MemWriteEn1_MEM(MemWriteEn1_MEM), .MemWriteEn2_MEM(MemWriteEn2_MEM),
      .MemtoReg1_MEM(MemtoReg1_MEM), .MemtoReg2_MEM(MemtoReg2_MEM),
      .RegWriteEn1_MEM(RegWriteEn1_MEM), .RegWriteEn2_MEM(RegWriteEn2_MEM),
      .jal1_MEM(jal1_MEM), .jal2_MEM(jal2_MEM),
      .DestReg1_MEM(DestReg1_MEM), .DestReg2_MEM(DestReg2_MEM),
      .return_addr1_MEM(return_addr1_MEM), .return_addr2_MEM(return_addr2_MEM),
      .BranchAddress1_MEM(BranchAddress1_MEM), .BranchAddress2_MEM(BranchAddress2_MEM),
      .Branch1_MEM(Branch1_MEM), .Branch2_MEM(Branch2_MEM),
      .taken1_MEM(taken1_MEM), .taken2_MEM(taken2_MEM),
      .predicted1_MEM(predicted1_MEM), .predicted2_MEM(predicted2_MEM),
      .stall_mem(stall_mem), .correct_en(correct_en), .correction(correction),
      .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
      .writeData1_WB(writeData1_WB), .writeData2_WB(writeData2_WB),
      .aluRes1_WB(aluRes1_WB), .aluRes2_WB(aluRes2_WB),
      .writeReg1_WB(writeReg1_WB), .writeReg2_WB(writeReg2_WB),
      .regWrite1_WB(regWrite1_WB), .regWrite2_WB(regWrite2_WB),
      .jal1_WB(jal1_WB), .jal2_WB(jal2_WB)
   );

   function automatic bundle_t nop_bundle();
      bundle_t b;
      b = '{default: '0};
      return b;
   endfunction

   task automatic drive(input bundle_t b);
      aluRes1_MEM = b.alu1;        aluRes2_MEM = b.alu2;
      forwardBRes1_MEM = b.fb1;    forwardBRes2_MEM = b.fb2;
      MemReadEn1_MEM = b.rd1;      MemReadEn2_MEM = b.rd2;
      MemWriteEn1_MEM = b.wr1;     MemWriteEn2_MEM = b.wr2;
      MemtoReg1_MEM = b.m2r1;      MemtoReg2_MEM = b.m2r2;
      RegWriteEn1_MEM = b.rw1;     RegWriteEn2_MEM = b.rw2;
      jal1_MEM = b.jl1;            jal2_MEM = b.jl2;
      DestReg1_MEM = b.d1;         DestReg2_MEM = b.d2;
      return_addr1_MEM = b.ra1;    return_addr2_MEM = b.ra2;
      BranchAddress1_MEM = b.ba1;  BranchAddress2_MEM = b.ba2;
      Branch1_MEM = b.br1;         Branch2_MEM = b.br2;
      taken1_MEM = b.tk1;          taken2_MEM = b.tk2;
      predicted1_MEM = b.pr1;      predicted2_MEM = b.pr2;
   endtask

   // Executes one bundle as two sequential instructions (older slot first) on
   // the reference memory, then drives it and compares the DUT behaviour.
   task automatic run_bundle(input bundle_t b, input string name);
      logic        mis1, mis2, two, ece;
      logic [9:0]  a1, a2, ecorr;
      logic [31:0] ld1, ld2, ewd1, ewd2;
      a1   = b.alu1[9:0];
      a2   = b.alu2[9:0];
      mis1 = b.br1 && (b.tk1 != b.pr1);
      mis2 = b.br2 && (b.tk2 != b.pr2);
      two  = (b.rd1 || b.wr1) && (b.rd2 || b.wr2) && !mis1;
      ld1  = ref_mem[a1];
      if (b.wr1) ref_mem[a1] = b.fb1;
      ld2  = ref_mem[a2];
      if (b.wr2 && !mis1) ref_mem[a2] = b.fb2;
      ewd1 = b.jl1 ? {22'b0, b.ra1} : (b.m2r1 ? ld1 : b.alu1);
      ewd2 = b.jl2 ? {22'b0, b.ra2} : (b.m2r2 ? ld2 : b.alu2);
      ece  = mis1 || mis2;
      ecorr = mis1 ? (b.tk1 ? b.ba1 : b.ra1) : (mis2 ? (b.tk2 ? b.ba2 : b.ra2) : 10'd0);

      @(negedge clk);
      drive(b);
      #1;
      obs_stall = stall_mem;
      checks++;
      if (stall_mem !== two) begin
         failures++;
         $display("FAIL %s stall_mem got=%0b exp=%0b", name, stall_mem, two);
      end
      if (two) begin
         checks++;
         if (correct_en !== 1'b0) begin
            failures++;
            $display("FAIL %s correct_en_in_stall got=%0b exp=0", name, correct_en);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB} !== 4'b0000) begin
            failures++;
            $display("FAIL %s bubble rw1/rw2/jal1/jal2 got=%b exp=0000", name,
                     {regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB});
         end
         checks++;
         if (stall_mem !== 1'b0) begin
            failures++;
            $display("FAIL %s stall_mem_second got=%0b exp=0", name, stall_mem);
         end
      end
      obs_ce   = correct_en;
      obs_corr = correction;
      checks++;
      if (correct_en !== ece) begin
         failures++;
         $display("FAIL %s correct_en got=%0b exp=%0b", name, correct_en, ece);
      end
      checks++;
      if (correction !== ecorr) begin
         failures++;
         $display("FAIL %s correction got=%0h exp=%0h", name, correction, ecorr);
      end
      checks++;
      if ({flush_IFID, flush_IDEX} !== {ece, ece}) begin
         failures++;
         $display("FAIL %s flush got=%b exp=%b", name, {flush_IFID, flush_IDEX}, {ece, ece});
      end

      @(posedge clk);
      #1;
      checks++;
      if (writeData1_WB !== ewd1) begin
         failures++;
         $display("FAIL %s writeData1_WB got=%0h exp=%0h", name, writeData1_WB, ewd1);
      end
      checks++;
      if ({writeReg1_WB, regWrite1_WB, jal1_WB, aluRes1_WB} !== {b.d1, b.rw1, b.jl1, b.alu1}) begin
         failures++;
         $display("FAIL %s slot1_ctl got=%0h/%0b/%0b/%0h exp=%0h/%0b/%0b/%0h", name,
                  writeReg1_WB, regWrite1_WB, jal1_WB, aluRes1_WB, b.d1, b.rw1, b.jl1, b.alu1);
      end
      if (!mis1) begin
         checks++;
         if (writeData2_WB !== ewd2) begin
            failures++;
            $display("FAIL %s writeData2_WB got=%0h exp=%0h", name, writeData2_WB, ewd2);
         end
      end
      checks++;
      if ({writeReg2_WB, regWrite2_WB, jal2_WB, aluRes2_WB} !==
          {b.d2, b.rw2 && !mis1, b.jl2, b.alu2}) begin
         failures++;
         $display("FAIL %s slot2_ctl got=%0h/%0b/%0b/%0h exp=%0h/%0b/%0b/%0h", name,
                  writeReg2_WB, regWrite2_WB, jal2_WB, aluRes2_WB,
                  b.d2, b.rw2 && !mis1, b.jl2, b.alu2);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(nop_bundle());
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({stall_mem, correct_en, correction, regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB} !== 16'd0) begin
         failures++;
         $display("FAIL reset_ctl got=%0h exp=0", {stall_mem, correct_en, correction,
                  regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB});
      end
      checks++;
      if ({writeData1_WB, writeData2_WB, aluRes1_WB, aluRes2_WB, writeReg1_WB, writeReg2_WB} !== 138'd0) begin
         failures++;
         $display("FAIL reset_data got=%0h/%0h/%0h/%0h exp=0", writeData1_WB, writeData2_WB,
                  aluRes1_WB, aluRes2_WB);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_init_mem();
      bundle_t b;
      for (int a = 0; a < 32; a++) begin
         b = nop_bundle();
         if (a[0]) begin
            b.wr2 = 1'b1; b.alu2 = 32'(a); b.fb2 = $urandom;
         end else begin
            b.wr1 = 1'b1; b.alu1 = 32'(a); b.fb1 = $urandom;
         end
         run_bundle(b, "init_store");
      end
   endtask

   task automatic test_store_load_conflict();
      bundle_t b;
      b = nop_bundle();
      b.wr1 = 1'b1; b.alu1 = 32'd5; b.fb1 = 32'hAAAA;
      b.rd2 = 1'b1; b.m2r2 = 1'b1; b.rw2 = 1'b1; b.alu2 = 32'd5; b.d2 = 5'd8;
      run_bundle(b, "sw_lw_conflict");
      checks++;
      if (writeData2_WB !== 32'hAAAA || writeReg2_WB !== 5'd8 || obs_stall !== 1'b1) begin
         failures++;
         $display("FAIL sw_lw_direct got=%0h/%0d/%0b exp=aaaa/8/1", writeData2_WB, writeReg2_WB, obs_stall);
      end
   endtask

   task automatic test_same_addr_stores();
      bundle_t b;
      b = nop_bundle();
      b.wr1 = 1'b1; b.alu1 = 32'd7; b.fb1 = 32'h11;
      b.wr2 = 1'b1; b.alu2 = 32'd7; b.fb2 = 32'h22;
      run_bundle(b, "sw_sw_same");
      b = nop_bundle();
      b.rd1 = 1'b1; b.m2r1 = 1'b1; b.rw1 = 1'b1; b.alu1 = 32'd7; b.d1 = 5'd2;
      run_bundle(b, "lw_after_sw_sw");
      checks++;
      if (writeData1_WB !== 32'h22) begin
         failures++;
         $display("FAIL sw_sw_persist got=%0h exp=22", writeData1_WB);
      end
   endtask

   task automatic test_mispredict_slot1();
      bundle_t b;
      logic [31:0] old9;
      old9 = ref_mem[9];
      b = nop_bundle();
      b.br1 = 1'b1; b.tk1 = 1'b1; b.pr1 = 1'b0; b.ba1 = 10'h040; b.ra1 = 10'h111;
      b.wr2 = 1'b1; b.alu2 = 32'd9; b.fb2 = 32'hDEAD; b.rw2 = 1'b1; b.d2 = 5'd4;
      run_bundle(b, "mis1_squash");
      checks++;
      if (obs_ce !== 1'b1 || obs_corr !== 10'h040 || obs_stall !== 1'b0 || regWrite2_WB !== 1'b0) begin
         failures++;
         $display("FAIL mis1_direct ce/corr/stall/rw2 got=%0b/%0h/%0b/%0b exp=1/40/0/0",
                  obs_ce, obs_corr, obs_stall, regWrite2_WB);
      end
      b = nop_bundle();
      b.rd1 = 1'b1; b.m2r1 = 1'b1; b.rw1 = 1'b1; b.alu1 = 32'd9;
      run_bundle(b, "mis1_no_store");
      checks++;
      if (writeData1_WB !== old9) begin
         failures++;
         $display("FAIL mis1_no_store got=%0h exp=%0h", writeData1_WB, old9);
      end
   endtask

   task automatic test_mispredict_slot2();
      bundle_t b;
      b = nop_bundle();
      b.alu1 = 32'h1234; b.rw1 = 1'b1; b.d1 = 5'd3;
      b.br2 = 1'b1; b.tk2 = 1'b0; b.pr2 = 1'b1; b.ra2 = 10'h013; b.ba2 = 10'h2AA;
      run_bundle(b, "mis2");
      checks++;
      if (obs_corr !== 10'h013 || writeData1_WB !== 32'h1234 || regWrite1_WB !== 1'b1) begin
         failures++;
         $display("FAIL mis2_direct corr/wd1/rw1 got=%0h/%0h/%0b exp=13/1234/1",
                  obs_corr, writeData1_WB, regWrite1_WB);
      end
   endtask

   task automatic test_jal_wrap();
      bundle_t b;
      b = nop_bundle();
      b.jl1 = 1'b1; b.rw1 = 1'b1; b.d1 = 5'd31; b.ra1 = 10'h3FF; b.alu1 = 32'hFFFF_FFFF;
      b.wr2 = 1'b1; b.alu2 = 32'h40A; b.fb2 = 32'h5A5A;
      run_bundle(b, "jal_wrap_store");
      checks++;
      if (writeData1_WB !== 32'h3FF || jal1_WB !== 1'b1) begin
         failures++;
         $display("FAIL jal_direct got=%0h/%0b exp=3ff/1", writeData1_WB, jal1_WB);
      end
      b = nop_bundle();
      b.rd2 = 1'b1; b.m2r2 = 1'b1; b.rw2 = 1'b1; b.alu2 = 32'h00A;
      run_bundle(b, "wrap_load");
      checks++;
      if (writeData2_WB !== 32'h5A5A) begin
         failures++;
         $display("FAIL wrap_direct got=%0h exp=5a5a", writeData2_WB);
      end
   endtask

   task automatic test_reset_mid_second();
      bundle_t b;
      logic [31:0] old21;
      old21 = ref_mem[21];
      b = nop_bundle();
      b.wr1 = 1'b1; b.alu1 = 32'd20; b.fb1 = 32'hCAFE0001;
      b.wr2 = 1'b1; b.alu2 = 32'd21; b.fb2 = 32'hCAFE0002;
      @(negedge clk);
      drive(b);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(nop_bundle());
      #1;
      checks++;
      if ({stall_mem, regWrite1_WB, regWrite2_WB} !== 3'b000 || writeData1_WB !== 32'd0) begin
         failures++;
         $display("FAIL rst_second got=%b/%0h exp=000/0", {stall_mem, regWrite1_WB, regWrite2_WB}, writeData1_WB);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ref_mem[20] = 32'hCAFE0001;
      b = nop_bundle();
      b.rd1 = 1'b1; b.m2r1 = 1'b1; b.alu1 = 32'd20;
      b.rd2 = 1'b1; b.m2r2 = 1'b1; b.alu2 = 32'd21;
      run_bundle(b, "rst_readback");
      checks++;
      if (writeData1_WB !== 32'hCAFE0001 || writeData2_WB !== old21) begin
         failures++;
         $display("FAIL rst_mem got=%0h/%0h exp=cafe0001/%0h", writeData1_WB, writeData2_WB, old21);
      end
   endtask

   task automatic test_random();
      bundle_t b;
      for (int n = 0; n < 150; n++) begin
         b = nop_bundle();
         for (int k = 0; k < 2; k++) begin
            int unsigned op;
            logic [31:0] alu, maddr;
            logic rd, wr, rw, jl, br, tk, pr;
            op    = $urandom_range(0, 4);
            alu   = $urandom;
            maddr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
            rd = 1'b0; wr = 1'b0; rw = 1'b0; jl = 1'b0; br = 1'b0;
            tk = 1'($urandom_range(0, 1));
            pr = 1'($urandom_range(0, 1));
            case (op)
               0: rw = 1'($urandom_range(0, 1));
               1: begin rd = 1'b1; rw = 1'b1; alu = maddr; end
               2: begin wr = 1'b1; alu = maddr; end
               3: br = 1'b1;
               default: begin jl = 1'b1; rw = 1'b1; end
            endcase
            if (k == 0) begin
               b.alu1 = alu; b.rd1 = rd; b.wr1 = wr; b.m2r1 = rd; b.rw1 = rw; b.jl1 = jl;
               b.br1 = br; b.tk1 = tk; b.pr1 = pr; b.fb1 = $urandom;
               b.d1 = 5'($urandom); b.ra1 = 10'($urandom); b.ba1 = 10'($urandom);
            end else begin
               b.alu2 = alu; b.rd2 = rd; b.wr2 = wr; b.m2r2 = rd; b.rw2 = rw; b.jl2 = jl;
               b.br2 = br; b.tk2 = tk; b.pr2 = pr; b.fb2 = $urandom;
               b.d2 = 5'($urandom); b.ra2 = 10'($urandom); b.ba2 = 10'($urandom);
            end
         end
         run_bundle(b, "random");
      end
   endtask

   initial begin
      test_reset();
      test_init_mem();
      test_store_load_conflict();
      test_same_addr_stores();
      test_mispredict_slot1();
      test_mispredict_slot2();
      test_jal_wrap();
      test_reset_mid_second();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
